// File: rtl/timebase_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : timebase_ctrl
// Description : Run/pause/clear controller and programmable timebase.
//               Produces single-cycle clock enables on the global clock:
//               a gated, rate-selectable tick for the counting datapath and
//               a free-running 1 kHz tick_scan for display multiplexing.
//               A three-state FSM (IDLE/RUN/PAUSE) driven by one-shot button
//               pulses sequences the gated tick.
// Ports       : clk        - global clock, rising edge
//               rst_n      - asynchronous active-low reset
//               start      - one-cycle pulse, toggles run/pause
//               clear      - one-cycle pulse, return to IDLE (wins over start)
//               rate_sel   - 00=1 Hz, 01=10 Hz, 10=100 Hz, 11=1 kHz
//               tick       - one-cycle enable at the selected rate, RUN only
//               tick_scan  - one-cycle enable at 1 kHz, always active
//               run        - high in RUN
//               paused     - high in PAUSE
//               clk_sq     - rate/2 square wave (TIMEBASE_SQUARE_EN), else 0
// Parameters  : CLK_HZ (multiple of 1000), CNT_W (2**CNT_W > CLK_HZ)
// Config      : `define TIMEBASE_SQUARE_EN builds the clk_sq toggle flop
// Revision    : 1.0 - initial release
// ============================================================================
module timebase_ctrl #(
    parameter int CLK_HZ = 100000000,
    parameter int CNT_W  = 27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       clear,
    input  logic [1:0] rate_sel,
    output logic       tick,
    output logic       tick_scan,
    output logic       run,
    output logic       paused,
    output logic       clk_sq
);

    localparam logic [CNT_W-1:0] TERM_1HZ    = CNT_W'(CLK_HZ - 1);
    localparam logic [CNT_W-1:0] TERM_10HZ   = CNT_W'(CLK_HZ / 10 - 1);
    localparam logic [CNT_W-1:0] TERM_100HZ  = CNT_W'(CLK_HZ / 100 - 1);
    localparam logic [CNT_W-1:0] TERM_1KHZ   = CNT_W'(CLK_HZ / 1000 - 1);
    localparam logic [CNT_W-1:0] SCAN_TERM   = CNT_W'(CLK_HZ / 1000 - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       rate_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] scnt;
    logic [CNT_W-1:0] term;
    logic             rate_change;
    logic             wrap;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = ST_IDLE;
        end else if (start) begin
            case (state)
                ST_IDLE:  state_next = ST_RUN;
                ST_RUN:   state_next = ST_PAUSE;
                ST_PAUSE: state_next = ST_RUN;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Rate selection. The registered copy both selects the terminal count
    // and flags a change: a mismatch with the live input restarts the
    // period from zero.
    // ------------------------------------------------------------------
    always_comb begin
        term = TERM_1KHZ;
        case (rate_q)
            2'b00:   term = TERM_1HZ;
            2'b01:   term = TERM_10HZ;
            2'b10:   term = TERM_100HZ;
            default: term = TERM_1KHZ;
        endcase
    end

    assign rate_change = (rate_q != rate_sel);

    // A period completes only while genuinely running; clear or a rate
    // change on the same edge discards it so no tick leaks into IDLE.
    // start does not suppress it: a pause on the terminal edge still ticks.
    assign wrap = (state == ST_RUN) && (cnt == term) && !clear && !rate_change;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rate_q <= 2'b00;
        end else begin
            rate_q <= rate_sel;
        end
    end

    // ------------------------------------------------------------------
    // Main divider. Holds in PAUSE so resume keeps the phase.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= wrap;
            if (clear || rate_change || state == ST_IDLE || wrap) begin
                cnt <= '0;
            end else if (state == ST_RUN) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Status outputs, registered from the next state so they change on the
    // edge that samples start/clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run    <= 1'b0;
            paused <= 1'b0;
        end else begin
            run    <= (state_next == ST_RUN);
            paused <= (state_next == ST_PAUSE);
        end
    end

    // ------------------------------------------------------------------
    // Free-running scan divider, independent of the FSM and rate select.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt      <= '0;
            tick_scan <= 1'b0;
        end else begin
            if (scnt == SCAN_TERM) begin
                scnt      <= '0;
                tick_scan <= 1'b1;
            end else begin
                scnt      <= scnt + CNT_W'(1);
                tick_scan <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional square wave: toggles with every tick, holds in PAUSE,
    // returns to 0 whenever the controller is (or is entering) IDLE.
    // ------------------------------------------------------------------
`ifdef TIMEBASE_SQUARE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sq <= 1'b0;
        end else if (clear || state == ST_IDLE) begin
            clk_sq <= 1'b0;
        end else if (wrap) begin
            clk_sq <= ~clk_sq;
        end
    end
`else
    assign clk_sq = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_timebase_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_timebase_ctrl
// Description : Self-checking bench for timebase_ctrl at CLK_HZ = 10000.
//               A behavioural model tracks RUN cycles per period and scan
//               edges since reset; every output is compared on each falling
//               edge. Directed scenarios add hand-computed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timebase_ctrl;

    localparam int CLK_HZ = 10000;
    localparam int CNT_W  = 14;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
`ifdef TIMEBASE_SQUARE_EN
    localparam logic SQ_EN = 1'b1;
`else
    localparam logic SQ_EN = 1'b0;
`endif

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       start    = 1'b0;
    logic       clear    = 1'b0;
    logic [1:0] rate_sel = 2'b00;
    logic       tick;
    logic       tick_scan;
    logic       run;
    logic       paused;
    logic       clk_sq;

    int checks   = 0;
    int failures = 0;

    timebase_ctrl #(
        .CLK_HZ (CLK_HZ),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .clear     (clear),
        .rate_sel  (rate_sel),
        .tick      (tick),
        .tick_scan (tick_scan),
        .run       (run),
        .paused    (paused),
        .clk_sq    (clk_sq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=%0b required=%0b t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    function automatic int period_of(input logic [1:0] r);
        case (r)
            2'b00:   return CLK_HZ;
            2'b01:   return CLK_HZ / 10;
            2'b10:   return CLK_HZ / 100;
            default: return CLK_HZ / 1000;
        endcase
    endfunction

    int         m_mode    = M_IDLE;
    int         m_elapsed = 0;
    int         m_sedge   = 0;
    logic [1:0] m_rate    = 2'b00;
    logic       m_tick    = 1'b0;
    logic       m_scan    = 1'b0;
    logic       m_sq      = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = M_IDLE; m_elapsed = 0; m_sedge = 0; m_rate = 2'b00;
            m_tick = 1'b0; m_scan = 1'b0; m_sq = 1'b0;
        end else begin
            m_tick  = 1'b0;
            m_sedge = m_sedge + 1;
            m_scan  = (m_sedge % (CLK_HZ / 1000)) == 0;
            if (clear) begin
                m_mode = M_IDLE; m_elapsed = 0; m_sq = 1'b0;
            end else begin
                if (rate_sel != m_rate) begin
                    m_elapsed = 0;
                end else if (m_mode == M_RUN) begin
                    m_elapsed = m_elapsed + 1;
                    if (m_elapsed == period_of(m_rate)) begin
                        m_tick = 1'b1; m_elapsed = 0; m_sq = ~m_sq;
                    end
                end else if (m_mode == M_IDLE) begin
                    m_elapsed = 0;
                end
                if (start) m_mode = (m_mode == M_RUN) ? M_PAUSE : M_RUN;
            end
            m_rate = rate_sel;
        end
    end

    always @(negedge clk) begin
        check("tick",      tick,      m_tick);
        check("tick_scan", tick_scan, m_scan);
        check("run",       run,       m_mode == M_RUN);
        check("paused",    paused,    m_mode == M_PAUSE);
        check("clk_sq",    clk_sq,    SQ_EN ? m_sq : 1'b0);
    end

    // ------------------------------------------------------------------
    // Directed stimulus; inputs change 2 time units after a rising edge
    // ------------------------------------------------------------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    int ticks_in_pause;
    int paused_low;

    initial begin
        // reset state
        cyc(2);
        check("rst_run", run, 1'b0);
        check("rst_paused", paused, 1'b0);
        check("rst_tick", tick, 1'b0);
        check("rst_scan", tick_scan, 1'b0);
        check("rst_sq", clk_sq, 1'b0);
        rst_n = 1'b1;
        // scan: first pulse 10 edges after release
        cyc(9);
        check("scan_first_early", tick_scan, 1'b0);
        cyc(1);
        check("scan_first", tick_scan, 1'b1);

        // 1 kHz run: first tick 10 edges after the state change
        rate_sel = 2'b11;
        cyc(1);
        pulse_start();
        check("s1_run", run, 1'b1);
        cyc(9);
        check("s1_tick_early", tick, 1'b0);
        cyc(1);
        check("s1_tick_first", tick, 1'b1);
        check("s1_sq_first", clk_sq, SQ_EN);
        cyc(1);
        check("s1_tick_gap", tick, 1'b0);
        cyc(9);
        check("s1_tick_second", tick, 1'b1);
        check("s1_sq_second", clk_sq, 1'b0);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        check("s1_clear_run", run, 1'b0);

        // 100 Hz pause/resume: pause after 40 RUN cycles, resume after 500
        rate_sel = 2'b10;
        cyc(1);
        pulse_start();
        cyc(39);
        pulse_start();
        check("s2_paused", paused, 1'b1);
        check("s2_run_low", run, 1'b0);
        ticks_in_pause = 0;
        paused_low     = 0;
        for (int i = 0; i < 500; i++) begin
            cyc(1);
            if (tick) ticks_in_pause++;
            if (!paused) paused_low++;
        end
        check("s2_no_tick_in_pause", ticks_in_pause == 0, 1'b1);
        check("s2_paused_held", paused_low == 0, 1'b1);
        pulse_start();
        check("s2_resume_run", run, 1'b1);
        cyc(59);
        check("s2_resume_early", tick, 1'b0);
        cyc(1);
        check("s2_resume_tick", tick, 1'b1);

        // start and clear together in RUN: clear wins, count restarts
        cyc(30);
        start = 1'b1;
        clear = 1'b1;
        cyc(1);
        start = 1'b0;
        clear = 1'b0;
        check("s3_run", run, 1'b0);
        check("s3_paused", paused, 1'b0);
        check("s3_tick", tick, 1'b0);
        cyc(120);
        pulse_start();
        cyc(99);
        check("s3_restart_early", tick, 1'b0);
        cyc(1);
        check("s3_restart_tick", tick, 1'b1);

        // rate change 1 Hz -> 1 kHz mid-count
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        rate_sel = 2'b00;
        cyc(1);
        pulse_start();
        cyc(5000);
        rate_sel = 2'b11;
        cyc(1);
        check("s4_no_tick_on_change", tick, 1'b0);
        cyc(9);
        check("s4_tick_early", tick, 1'b0);
        cyc(1);
        check("s4_tick_after_change", tick, 1'b1);

        // start on the terminal-count edge: tick still issued, then PAUSE at 0
        cyc(9);
        pulse_start();
        check("s5_term_tick", tick, 1'b1);
        check("s5_term_paused", paused, 1'b1);
        cyc(1);
        check("s5_term_tick_end", tick, 1'b0);
        cyc(20);
        pulse_start();
        cyc(9);
        check("s5_resume_early", tick, 1'b0);
        cyc(1);
        check("s5_resume_tick", tick, 1'b1);

        // asynchronous reset mid-RUN
        cyc(3);
        check("s6_pre_run", run, 1'b1);
        rst_n = 1'b0;
        #1;
        check("s6_async_run", run, 1'b0);
        check("s6_async_tick", tick, 1'b0);
        check("s6_async_scan", tick_scan, 1'b0);
        check("s6_async_paused", paused, 1'b0);
        check("s6_async_sq", clk_sq, 1'b0);
        cyc(3);
        rst_n = 1'b1;
        cyc(20);
        check("s6_idle_after", run, 1'b0);
        pulse_start();
        check("s6_restart_run", run, 1'b1);
        cyc(9);
        check("s6_restart_early", tick, 1'b0);
        cyc(1);
        check("s6_restart_tick", tick, 1'b1);

        cyc(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/timebase_ctrl.md
# timebase_ctrl

Run/pause/clear controller and programmable timebase for the lab display datapath. It replaces ad-hoc divided clocks with single-cycle clock enables, so all downstream counters stay on the global `clk`:
- A gated, rate-selectable `tick` for the counting datapath.
- A free-running `tick_scan` for 7-segment multiplexing.

A three-state FSM, driven by pre-debounced one-shot button pulses, sequences it.

## Interface
- `CLK_HZ`, default 100000000: global clock frequency; must be a multiple of 1000.
- `CNT_W`, default 27: divider counter width; must satisfy 2^CNT_W > CLK_HZ.
- `clk` input 1: global clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse; toggles run/pause.
- `clear` input 1: one-cycle pulse; returns to IDLE.
- `rate_sel` input 2: tick rate select. 00 = 1 Hz, 01 = 10 Hz, 10 = 100 Hz, 11 = 1 kHz.
- `tick` output 1: one-cycle enable at the selected rate; only in RUN.
- `tick_scan` output 1: one-cycle enable at 1 kHz; always active.
- `run` output 1: high in RUN.
- `paused` output 1: high in PAUSE.
- `clk_sq` output 1: square wave; see Configuration.

## Operation
- Terminal count: `term` = CLK_HZ/rate − 1, computed per `rate_sel` as CNT_W-bit constants.
- Main counter `cnt` (CNT_W bits). All outputs are registered.
- FSM states: IDLE, RUN, PAUSE. Reset state is IDLE.
- Transitions:
  - IDLE + `start` → RUN.
  - RUN + `start` → PAUSE.
  - PAUSE + `start` → RUN.
  - Any state + `clear` → IDLE.
  - Otherwise hold.
  - `start` and `clear` in the same cycle: `clear` wins.
- `cnt` behaviour by state:
  - IDLE: forced to 0.
  - RUN: increments. When `cnt` == `term`, it wraps to 0 and `tick` is set to 1 for the next cycle.
  - PAUSE: holds, so resume keeps the phase.
- `tick` is 0 in all other cycles. `tick` is never asserted in IDLE or PAUSE.
- Rate change: `rate_sel` is registered into `rate_q` every cycle. If `rate_q` differs from `rate_sel`, then on that edge `cnt` is set to 0 with no tick; the new period starts fresh. A rate change in PAUSE also zeroes `cnt`.
- Scan counter `scnt`:
  - Independent of the FSM.
  - Wraps at CLK_HZ/1000 − 1 and pulses `tick_scan` for one cycle.
  - Unaffected by `clear` and `rate_sel`.
- Overflow is impossible by construction: `cnt` never exceeds `term`.

## Timing
- Reset values: `tick` = 0, `tick_scan` = 0, `run` = 0, `paused` = 0, `clk_sq` = 0, `cnt` = 0, `scnt` = 0, FSM = IDLE, `rate_q` = 0.
- Reset mid-operation clears all of the above immediately (asynchronous). Operation resumes on the first edge after `rst_n` rises.
- `run` and `paused` update on the same edge that samples `start`/`clear`.
- First tick after entering RUN from IDLE: `tick` is high in the cycle starting term+1 edges after the state-change edge. Subsequent ticks are spaced exactly term+1 cycles apart.
- Pause/resume: RUN cycles accumulate across PAUSE; the total RUN cycles between ticks remain term+1.
- `start` asserted on the same edge that `cnt` reaches `term`: the tick is still issued, then the FSM moves to PAUSE with `cnt` = 0.
- `tick_scan`: first pulse CLK_HZ/1000 cycles after reset release; then periodic.

## Configuration
- `TIMEBASE_SQUARE_EN` defined:
  - `clk_sq` toggles on every edge where `tick` is set, giving a 50%-duty square wave at rate/2 for LED visualisation.
  - `clk_sq` holds its level in PAUSE and is forced to 0 in IDLE.
- `TIMEBASE_SQUARE_EN` undefined: `clk_sq` is tied to 0 and its toggle flop is not built.

## Test plan
All scenarios use CLK_HZ = 10000. Terminal counts: 1 Hz = 9999, 10 Hz = 999, 100 Hz = 99, 1 kHz = 9. Scan period = 10.
- Reset, then `rate_sel` = 11 with one `start` pulse → `run` = 1 the next cycle; `tick` pulses every 10 cycles, first 10 cycles after the state change; `tick_scan` period is 10 from reset.
- RUN at `rate_sel` = 10; pulse `start` at `cnt` = 40, wait 500 cycles, pulse `start` again → no ticks in PAUSE; next tick exactly 60 RUN cycles after resume; `paused` is high throughout.
- `start` and `clear` in the same cycle during RUN → IDLE, `run` = 0, `paused` = 0, `cnt` = 0, no tick.
- Change `rate_sel` 00 → 11 mid-count at `cnt` = 5000 → no tick on the change; next tick 10 cycles later.
- Drop `rst_n` for 3 cycles mid-RUN → all outputs 0 asynchronously; FSM in IDLE after release; `start` is required to resume.
- With `TIMEBASE_SQUARE_EN` and 1 kHz → `clk_sq` toggles every 10 cycles. Without the macro, `clk_sq` stays 0 through the whole run.
